// File: rtl/raw_video_timing_gen.sv
// Frame-accurate raw video source: reads a frame sequentially from a 1-cycle-latency pixel RAM
// and emits b_fval / b_lval / out_data with horizontal and vertical blanking.
module raw_video_timing_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 512,
    parameter int H_BLANK    = 80,
    parameter int V_PRE      = 2,
    parameter int V_POST     = 2,
    parameter int ADDR_W     = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  b_fval,
    output logic                  b_lval,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_MAX_A = (V_PRE > H_BLANK) ? V_PRE : H_BLANK;
    localparam int CNT_MAX   = (CNT_MAX_A > V_POST) ? CNT_MAX_A : V_POST;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int COL_W     = $clog2(WIDTH + 1);
    localparam int ROW_W     = $clog2(HEIGHT + 1);

    localparam logic [CNT_W-1:0] PRE_LAST     = CNT_W'(V_PRE - 1);
    localparam logic [CNT_W-1:0] PRE_PENULT   = CNT_W'(V_PRE - 2);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] BLANK_PENULT = CNT_W'(H_BLANK - 2);
    localparam logic [CNT_W-1:0] POST_LAST    = CNT_W'(V_POST - 1);
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(WIDTH - 1);
    localparam logic [COL_W-1:0] COL_PENULT   = COL_W'(WIDTH - 2);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACTIVE,
        S_BLANK,
        S_POST,
        S_END
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             fval_int;
    logic             rd_en_d;

    assign fval_int = (state == S_PRE) || (state == S_ACTIVE) ||
                      (state == S_BLANK) || (state == S_POST);
    assign busy     = (state != S_IDLE);

    // Reads are issued one cycle ahead of each ACTIVE line (last PRE / last BLANK cycle
    // through the second-to-last ACTIVE cycle) so the RAM latency plus the output register
    // lands each pixel exactly under b_lval, V_PRE cycles after b_fval rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            col     <= '0;
            row     <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            if (rd_en) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_PRE;
                        cnt     <= '0;
                        col     <= '0;
                        row     <= '0;
                        rd_addr <= '0;
                        rd_en   <= (V_PRE == 1);
                    end
                end
                S_PRE: begin
                    if (cnt == PRE_LAST) begin
                        state <= S_ACTIVE;
                        col   <= '0;
                        rd_en <= (WIDTH > 1);
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        rd_en <= (cnt == PRE_PENULT);
                    end
                end
                S_ACTIVE: begin
                    if (col == COL_LAST) begin
                        state <= S_BLANK;
                        cnt   <= '0;
                        rd_en <= (H_BLANK == 1) && (row != ROW_LAST);
                    end else begin
                        col   <= col + COL_W'(1);
                        rd_en <= (col != COL_PENULT);
                    end
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        row <= row + ROW_W'(1);
                        col <= '0;
                        cnt <= '0;
                        if (row == ROW_LAST) begin
                            rd_en <= 1'b0;
                            state <= (V_POST == 0) ? S_END : S_POST;
                        end else begin
                            rd_en <= (WIDTH > 1);
                            state <= S_ACTIVE;
                        end
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        rd_en <= (cnt == BLANK_PENULT) && (row != ROW_LAST);
                    end
                end
                S_POST: begin
                    if (cnt == POST_LAST) begin
                        state <= S_END;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_END: begin
                    // start is deliberately not looked at here: only continuous decides.
                    if (continuous) begin
                        state   <= S_PRE;
                        cnt     <= '0;
                        col     <= '0;
                        row     <= '0;
                        rd_addr <= '0;
                        rd_en   <= (V_PRE == 1);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_d    <= 1'b0;
            b_fval     <= 1'b0;
            b_lval     <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            rd_en_d    <= rd_en;
            b_fval     <= fval_int;
            b_lval     <= rd_en_d;
            out_data   <= rd_en_d ? rd_data : '0;
            frame_done <= b_fval & ~fval_int;
        end
    end

endmodule

// File: tb/tb_raw_video_timing_gen.sv
// Bench for raw_video_timing_gen: randomized start/continuous stimulus checked against a
// frame-arithmetic reference model plus a pixel scoreboard queue.
module tb_raw_video_timing_gen;

    localparam int DW        = 16;
    localparam int W         = 8;
    localparam int H         = 4;
    localparam int HB        = 3;
    localparam int VPRE      = 2;
    localparam int VPOST     = 2;
    localparam int AW        = 8;
    localparam int LINE      = W + HB;
    localparam int FRAME_LEN = 1 + VPRE + H * LINE + VPOST;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          continuous;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          b_fval;
    logic          b_lval;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          frame_done;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    int n_done_exp = 0;

    logic [DW-1:0] exp_q[$];
    logic m_busy = 1'b0;
    int   m_t    = 0;
    logic m_done = 1'b0;

    raw_video_timing_gen #(
        .DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .H_BLANK(HB),
        .V_PRE(VPRE), .V_POST(VPOST), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .b_fval(b_fval), .b_lval(b_lval), .out_data(out_data),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: word[a] = a, data valid one cycle after rd_en
    always @(posedge clk) begin
        if (rd_en) rd_data <= DW'(rd_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_fval(input logic bz, input int t);
        return bz && (t >= 1);
    endfunction

    function automatic logic exp_lval(input logic bz, input int t);
        int off;
        if (!bz) return 1'b0;
        off = t - 1 - VPRE;
        if (off < 0) return 1'b0;
        if (off / LINE >= H) return 1'b0;
        return (off % LINE) < W;
    endfunction

    task automatic push_frame();
        for (int a = 0; a < W * H; a++) exp_q.push_back(DW'(a));
    endtask

    // Reference model: m_t counts edges since the frame's PRE entry; a frame spans FRAME_LEN edges.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0;
                m_t    = 0;
                m_done = 1'b0;
                exp_q.delete();
            end else begin
                m_done = 1'b0;
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1'b1;
                        m_t    = 0;
                        push_frame();
                    end
                end else begin
                    m_t++;
                    if (m_t == FRAME_LEN) begin
                        m_done = 1'b1;
                        n_done_exp++;
                        if (continuous) begin
                            m_t = 0;
                            push_frame();
                        end else begin
                            m_busy = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compare every cycle on the falling edge, pop a pixel whenever b_lval is high.
    initial begin
        logic [DW-1:0] exp_v;
        forever begin
            @(negedge clk);
            check("fval", b_fval, exp_fval(m_busy, m_t));
            check("lval", b_lval, exp_lval(m_busy, m_t));
            check("busy", busy, m_busy);
            check("frame_done", frame_done, m_done);
            if (frame_done) done_seen++;
            if (b_lval) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pixel_underrun: got %0h expected none at %0t", out_data, $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("pixel", out_data, exp_v);
                end
            end else begin
                check("blank_data", out_data, 0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_fval", b_fval, 0);
        check("rst_lval", b_lval, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single frame
        d0 = done_seen;
        pulse_start();
        wait_idle(200, "single_idle");
        check("single_done_cnt", done_seen - d0, 1);

        // three back-to-back frames, continuous dropped during the third
        d0 = done_seen;
        continuous = 1'b1;
        pulse_start();
        repeat (2 * FRAME_LEN + 2) @(negedge clk);
        continuous = 1'b0;
        wait_idle(200, "cont_idle");
        check("cont_done_cnt", done_seen - d0, 3);

        // start during ACTIVE and coinciding with END is ignored
        d0 = done_seen;
        pulse_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (FRAME_LEN - 1 - 6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200, "ignore_idle");
        repeat (5) @(negedge clk);
        check("ignore_busy", busy, 0);
        check("ignore_done_cnt", done_seen - d0, 1);

        // randomized start / continuous traffic
        for (int it = 0; it < 6; it++) begin
            int cyc;
            cyc = 0;
            continuous = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            pulse_start();
            while ((busy || start) && cyc < 800) begin
                @(negedge clk);
                cyc++;
                start = (cyc < 150) && ($urandom_range(0, 24) == 0);
                if (cyc >= 120) continuous = 1'b0;
                else if ($urandom_range(0, 29) == 0) continuous = ~continuous;
            end
            start = 1'b0;
            @(negedge clk);
            check("rand_idle", busy, 0);
        end

        // reset in the middle of row 2 col 5
        continuous = 1'b0;
        pulse_start();
        repeat (1 + (VPRE - 1) + 2 * LINE + 5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_fval", b_fval, 0);
        check("mid_rst_lval", b_lval, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_addr", rd_addr, 0);
        check("mid_rst_done", frame_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_quiet", busy, 0);
        d0 = done_seen;
        pulse_start();
        wait_idle(200, "post_rst_idle");
        check("post_rst_done_cnt", done_seen - d0, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("done_total", done_seen, n_done_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
